// File: rtl/chu_pwm_pkg.sv
// Shared definitions for the double-buffered PWM slot core: register map,
// CTRL bit positions and the counting-mode / direction encodings.
package chu_pwm_pkg;

    localparam logic [4:0] ADDR_DVSR      = 5'h00;
    localparam logic [4:0] ADDR_CTRL      = 5'h01;
    localparam logic [4:0] ADDR_POL       = 5'h02;
    localparam logic [4:0] ADDR_STATUS    = 5'h03;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    localparam int MAX_CHANNELS = 16;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_t;

    // True when addr selects the shadow duty register of channel ch.
    function automatic logic duty_addr_hit(input logic [4:0] addr, input int ch);
        return addr == (ADDR_DUTY_BASE + 5'(ch));
    endfunction

endpackage

// File: rtl/chu_pwm_timebase.sv
// Prescaler plus R-bit duty counter, counting up (edge-aligned) or up/down
// (center-aligned); flags the tick on which the counter returns to zero.
module chu_pwm_timebase
    import chu_pwm_pkg::*;
#(
    parameter int R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  dvsr,
    input  logic         mode,
    input  logic         en,
    input  logic         restart,
    output logic [R-1:0] d,
    output logic         tick,
    output logic         bnd
);

    localparam logic [R-1:0] D_MAX = '1;
    localparam logic [R-1:0] D_ONE = R'(1);

    logic [31:0]  q_q, q_d;
    logic [R-1:0] d_q, d_d, d_step;
    cnt_dir_t     dir_q, dir_d, dir_step;

    // Counter value and direction that the next tick would produce.
    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        d_step   = d_q;
        dir_step = dir_q;
        if (mode == PWM_CENTER) begin
            if (dir_q == DIR_UP) begin
                if (d_q == D_MAX) begin
                    d_step   = d_q - D_ONE;
                    dir_step = DIR_DOWN;
                end else begin
                    d_step = d_q + D_ONE;
                end
            end else begin
                d_step = d_q - D_ONE;
                if (d_q == D_ONE) begin
                    dir_step = DIR_UP;
                end
            end
        end else begin
            d_step   = d_q + D_ONE;
            dir_step = DIR_UP;
        end
    end

    assign tick = (q_q == '0);

    // '>=' rather than '==' so a DVSR lowered below the running count wraps at once.
    always_comb begin
        q_d   = q_q;
        d_d   = d_q;
        dir_d = dir_q;
        if (!en || restart) begin
            q_d   = '0;
            d_d   = '0;
            dir_d = DIR_UP;
        end else begin
            q_d = (q_q >= dvsr) ? '0 : q_q + 32'd1;
            if (tick) begin
                d_d   = d_step;
                dir_d = dir_step;
            end
        end
    end

    assign bnd = en && !restart && tick && (d_step == '0);
    assign d   = d_q;

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            d_q   <= '0;
            dir_q <= DIR_UP;
        end else begin
            q_q   <= q_d;
            d_q   <= d_d;
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/chu_io_pwm_dbuf_core.sv
// MMIO PWM slot: register file, shadow/active duty double buffer, per-channel
// compare with polarity, period status and combinational readback.
module chu_io_pwm_dbuf_core
    import chu_pwm_pkg::*;
#(
    parameter int W = 6,
    parameter int R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm_out
);

    logic [31:0]  dvsr_q, dvsr_d;
    logic         en_q, en_d;
    pwm_mode_t    mode_q, mode_d;
    logic [W-1:0] pol_q, pol_d;
    logic [W-1:0] pwm_q, pwm_d;
    logic         done_q, done_d;
    logic [15:0]  pcnt_q, pcnt_d;
    logic [R:0]   shadow_q [W];
    logic [R:0]   shadow_d [W];
    logic [R:0]   active_q [W];
    logic [R:0]   active_d [W];

    logic         wr_en;
    logic         wr_ctrl;
    pwm_mode_t    wr_mode;
    logic         restart;
    logic [R-1:0] d;
    logic         tick;
    logic         bnd;
    logic         unused_sig;

    assign wr_en   = cs && write;
    assign wr_ctrl = wr_en && (addr == ADDR_CTRL);
    assign wr_mode = pwm_mode_t'(wr_data[CTRL_MODE_BIT]);

    // A mode change or a fresh enable restarts the period from zero.
    assign restart = wr_ctrl && ((wr_mode != mode_q) || (wr_data[CTRL_EN_BIT] && !en_q));

    // read has no side effects and tick is only needed inside the timebase.
    assign unused_sig = ^{read, tick};

    chu_pwm_timebase #(
        .R (R)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .dvsr    (dvsr_q),
        .mode    (mode_q),
        .en      (en_q),
        .restart (restart),
        .d       (d),
        .tick    (tick),
        .bnd     (bnd)
    );

    always_comb begin
        dvsr_d   = dvsr_q;
        en_d     = en_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        shadow_d = shadow_q;
        if (wr_en) begin
            case (addr)
                ADDR_DVSR: dvsr_d = wr_data;
                ADDR_CTRL: begin
                    en_d   = wr_data[CTRL_EN_BIT];
                    mode_d = wr_mode;
                end
                ADDR_POL:  pol_d = wr_data[W-1:0];
                default:   ;
            endcase
        end
        for (int i = 0; i < W; i++) begin
            if (wr_en && duty_addr_hit(addr, i)) begin
                shadow_d[i] = wr_data[R:0];
            end
        end
    end

    // Active duties follow the shadows freely while disabled and only at a
    // period boundary while running; a boundary-cycle shadow write waits a period.
    always_comb begin
        active_d = active_q;
        done_d   = done_q;
        pcnt_d   = pcnt_q;
        if (!en_q || bnd) begin
            active_d = shadow_q;
        end
        if (bnd) begin
            done_d = 1'b1;
            pcnt_d = pcnt_q + 16'd1;
        end else if (wr_en && (addr == ADDR_STATUS)) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        pwm_d = pol_q;
        if (en_q) begin
            for (int i = 0; i < W; i++) begin
                pwm_d[i] = ({1'b0, d} < active_q[i]) ^ pol_q[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DVSR: rd_data = dvsr_q;
            ADDR_CTRL: begin
                rd_data[CTRL_MODE_BIT] = mode_q;
                rd_data[CTRL_EN_BIT]   = en_q;
            end
            ADDR_POL:  rd_data[W-1:0] = pol_q;
            ADDR_STATUS: begin
                rd_data[31:16] = pcnt_q;
                rd_data[0]     = done_q;
            end
            default: begin
                for (int i = 0; i < W; i++) begin
                    if (duty_addr_hit(addr, i)) begin
                        rd_data[R:0] = shadow_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr_q <= '0;
            en_q   <= 1'b0;
            mode_q <= PWM_EDGE;
            pol_q  <= '0;
            pwm_q  <= '0;
            done_q <= 1'b0;
            pcnt_q <= '0;
            // NOTE: the duty arrays are architectural registers with defined reset values, so they are cleared here rather than left as uninitialised storage.
            for (int i = 0; i < W; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            dvsr_q   <= dvsr_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pwm_q    <= pwm_d;
            done_q   <= done_d;
            pcnt_q   <= pcnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_chu_io_pwm_dbuf_core.sv
// Self-checking bench for chu_io_pwm_dbuf_core (W=4, R=4): directed scenarios
// plus randomized traffic against a period/tick-count reference model.
module tb_chu_io_pwm_dbuf_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  pwm_out;

    int n_vec = 0;
    int n_err = 0;
    int hi [4];

    // Reference model state, expressed as ticks into the current period.
    bit          m_en;
    bit          m_mode;
    logic [31:0] m_dvsr;
    logic [31:0] m_ph;
    logic [3:0]  m_pol;
    logic [3:0]  m_pwm;
    int          m_t;
    logic [4:0]  m_shadow [4];
    logic [4:0]  m_act [4];
    bit          m_done;
    logic [15:0] m_pcnt;

    logic [4:0]  rd_list [12] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11,
                                  5'h12, 5'h13, 5'h14, 5'h15, 5'h07, 5'h1f};

    chu_io_pwm_dbuf_core #(
        .W (4),
        .R (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int period_of(input bit mode);
        return mode ? 30 : 16;
    endfunction

    // Counter value after t ticks of a period: sawtooth or triangle.
    function automatic int d_of(input int t, input bit mode);
        int p;
        p = t % period_of(mode);
        if (!mode) return p;
        return (p <= 15) ? p : 30 - p;
    endfunction

    function automatic int high_per_period(input bit mode, input int duty, input int dvsr, input bit inv);
        int n;
        n = 0;
        for (int t = 0; t < period_of(mode); t++) begin
            if (d_of(t, mode) < duty) n += dvsr + 1;
        end
        return inv ? period_of(mode) * (dvsr + 1) - n : n;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a)
            5'h00: return m_dvsr;
            5'h01: return {30'd0, m_mode, m_en};
            5'h02: return {28'd0, m_pol};
            5'h03: return {m_pcnt, 15'd0, m_done};
            5'h10, 5'h11, 5'h12, 5'h13: return {27'd0, m_shadow[a[1:0]]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_dvsr = 0; m_ph = 0; m_pol = 0; m_pwm = 0;
        m_t = 0; m_done = 0; m_pcnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 0;
            m_act[i]    = 0;
        end
    endtask

    // Advance one clock: update the model from the bus values of this cycle,
    // then compare pwm_out just after the edge.
    task automatic cycle();
        logic [3:0] npwm;
        bit wr, restart, tick, bnd;
        int d;
        wr = cs && write;
        d  = d_of(m_t, m_mode);
        for (int i = 0; i < 4; i++) begin
            npwm[i] = m_en ? ((d < int'(m_act[i])) ^ m_pol[i]) : m_pol[i];
        end
        restart = wr && (addr == 5'h01) && ((wr_data[1] != m_mode) || (wr_data[0] && !m_en));
        tick    = (m_ph == 32'd0);
        bnd     = m_en && !restart && tick && (((m_t + 1) % period_of(m_mode)) == 0);
        if (!m_en || bnd) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_shadow[i];
        end
        if (!m_en || restart) begin
            m_t  = 0;
            m_ph = 0;
        end else begin
            if (tick) m_t = (m_t + 1) % period_of(m_mode);
            m_ph = (m_ph >= m_dvsr) ? 32'd0 : m_ph + 32'd1;
        end
        if (bnd) begin
            m_done = 1;
            m_pcnt = m_pcnt + 16'd1;
        end else if (wr && addr == 5'h03) begin
            m_done = 0;
        end
        if (wr) begin
            case (addr)
                5'h00: m_dvsr = wr_data;
                5'h01: begin m_en = wr_data[0]; m_mode = wr_data[1]; end
                5'h02: m_pol = wr_data[3:0];
                5'h10, 5'h11, 5'h12, 5'h13: m_shadow[addr[1:0]] = wr_data[4:0];
                default: ;
            endcase
        end
        m_pwm = npwm;
        @(posedge clk);
        #1;
        check("pwm_out", {28'd0, pwm_out}, {28'd0, m_pwm});
        for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] dat);
        cs = 1; write = 1; addr = a; wr_data = dat;
        cycle();
        cs = 0; write = 0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input string tag);
        addr = a; read = 1;
        #1;
        check(tag, rd_data, exp_rd(a));
        read = 0;
    endtask

    task automatic clear_hi();
        for (int i = 0; i < 4; i++) hi[i] = 0;
    endtask

    task automatic do_reset();
        #1 reset = 1;
        model_reset();
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        logic [31:0] rv;
        reset = 1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
        model_reset();
        clear_hi();

        // Reset state
        #1;
        check("reset_pwm", {28'd0, pwm_out}, 32'd0);
        addr = 5'h00; #1 check("reset_dvsr", rd_data, 32'd0);
        addr = 5'h03; #1 check("reset_status", rd_data, 32'd0);
        @(posedge clk);
        #1 reset = 0;

        // Edge-aligned duties: 4, 0, 16 (saturated), 9
        wr(5'h10, 4); wr(5'h11, 0); wr(5'h12, 16); wr(5'h13, 9);
        wr(5'h01, 32'h1);
        run(16);
        clear_hi(); run(16);
        check("edge_ch0_high", hi[0], high_per_period(0, 4, 0, 0));
        check("edge_ch1_high", hi[1], 32'd0);
        check("edge_ch2_high", hi[2], 32'd16);
        check("edge_ch3_high", hi[3], high_per_period(0, 9, 0, 0));

        // Center-aligned, duty0 = 5
        wr(5'h01, 32'h3);
        wr(5'h10, 5);
        run(30);
        clear_hi(); run(30);
        check("center_ch0_high", hi[0], high_per_period(1, 5, 0, 0));
        check("center_ch2_high", hi[2], 32'd30);
        check("center_ch3_high", hi[3], high_per_period(1, 9, 0, 0));

        // Double buffer: mid-period shadow write 8 -> 2
        wr(5'h01, 32'h0);
        wr(5'h10, 8);
        wr(5'h01, 32'h1);
        clear_hi();
        run(3);
        wr(5'h10, 2);
        addr = 5'h10; #1 check("shadow_readback", rd_data, 32'd2);
        run(12);
        check("dbuf_old_width", hi[0], 32'd8);
        clear_hi(); run(16);
        check("dbuf_new_width", hi[0], 32'd2);

        // Prescaler + inverted polarity
        wr(5'h01, 32'h0);
        wr(5'h00, 2); wr(5'h02, 32'h1); wr(5'h10, 4);
        wr(5'h01, 32'h1);
        clear_hi(); run(48);
        check("prescale_inv_high", hi[0], high_per_period(0, 4, 2, 1));

        // DVSR lowered below the running prescale count
        wr(5'h00, 100);
        run(51);
        wr(5'h00, 1);
        wr(5'h03, 0);
        run(40);
        addr = 5'h03; #1 check("dvsr_no_lockup", {31'd0, rd_data[0]}, 32'd1);
        rd_chk(5'h00, "dvsr_readback");

        // Status: period count and set-wins-over-clear
        do_reset();
        wr(5'h01, 32'h1);
        run(48);
        addr = 5'h03; #1 check("status_3_periods", rd_data, {16'd3, 15'd0, 1'b1});
        run(15);
        wr(5'h03, 0);
        addr = 5'h03; #1 check("status_set_wins", rd_data, {16'd4, 15'd0, 1'b1});
        wr(5'h03, 0);
        addr = 5'h03; #1 check("status_cleared", rd_data, {16'd4, 15'd0, 1'b0});

        // Disable mid-period: outputs settle to POL
        wr(5'h10, 7); wr(5'h02, 32'h5);
        run(20);
        wr(5'h01, 32'h0);
        cycle();
        check("disable_pwm_pol", {28'd0, pwm_out}, 32'h5);

        // Asynchronous reset mid-period: outputs 0, not POL
        wr(5'h01, 32'h1);
        run(7);
        #1 reset = 1;
        #1 check("async_reset_pwm", {28'd0, pwm_out}, 32'd0);
        addr = 5'h02; #1 check("async_reset_pol", rd_data, 32'd0);
        addr = 5'h10; #1 check("async_reset_duty", rd_data, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        run(4);

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            wr(5'h00, $urandom_range(0, 3));
            wr(5'h02, $urandom_range(0, 15));
            for (int ch = 0; ch < 4; ch++) wr(5'h10 + 5'(ch), $urandom_range(0, 17));
            wr(5'h01, {30'd0, 1'(r % 2), 1'b1});
            for (int c = 0; c < 150; c++) begin
                rv = $urandom_range(0, 15);
                if (rv < 3)       wr(5'h10 + 5'($urandom_range(0, 5)), $urandom_range(0, 17));
                else if (rv == 3) wr(5'h03, $urandom);
                else if (rv == 4) wr(5'h00, $urandom_range(0, 3));
                else if (rv == 5 && c % 5 == 0)
                    wr(5'h01, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
                else              cycle();
            end
            for (int k = 0; k < 12; k++) begin
                rd_chk(rd_list[k], "rand_readback");
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
